// File: rtl/fd_stall_ctrl.sv
// IF/ID register owner: turns stall/flush/halt into PC enable, IF/ID hold/flush, ID/EX bubble.
// Ports: clk, rst_n (async low); stallFD, flushD, halt_D, instr_F, pc_plus2_F in;
//   pc_en, bubble_X (comb), instr_D, pc_plus2_D, valid_D, halted, stall_err,
//   stall_cnt, flush_cnt out. Define STALL_PERF_EN to build the perf counters.
module fd_stall_ctrl #(
  parameter int INSTR_W = 16,
  parameter int PC_W = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int MAX_STALL = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stallFD,
  input  logic               flushD,
  input  logic               halt_D,
  input  logic [INSTR_W-1:0] instr_F,
  input  logic [PC_W-1:0]    pc_plus2_F,
  output logic               pc_en,
  output logic               bubble_X,
  output logic [INSTR_W-1:0] instr_D,
  output logic [PC_W-1:0]    pc_plus2_D,
  output logic               valid_D,
  output logic               halted,
  output logic               stall_err,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam int RUN_W = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e             state_q;
  logic [RUN_W-1:0]   run_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;
  logic               valid_q;
  logic               halted_q;
  logic               err_q;

  assign pc_en      = ~stallFD & ~halted_q;
  assign bubble_X   = stallFD | halted_q;
  assign instr_D    = instr_q;
  assign pc_plus2_D = pc_q;
  assign valid_D    = valid_q;
  assign halted     = halted_q;
  assign stall_err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      run_q    <= '0;
      instr_q  <= NOP_INSTR;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        RUN, STALL: begin
          if (stallFD) begin
            state_q <= STALL;
            if (state_q == RUN) begin
              run_q <= RUN_W'(1);
            end else begin
              if (run_q != '1)
                run_q <= run_q + RUN_W'(1);
              // One more stalled edge beyond the legal maximum
              if (run_q == RUN_W'(MAX_STALL))
                err_q <= 1'b1;
            end
          end else begin
            state_q <= RUN;
            run_q   <= '0;
            if (flushD) begin
              instr_q <= NOP_INSTR;
              pc_q    <= pc_plus2_F;
              valid_q <= 1'b0;
            end else if (halt_D && valid_q) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
              instr_q  <= NOP_INSTR;
              valid_q  <= 1'b0;
            end else begin
              instr_q <= instr_F;
              pc_q    <= pc_plus2_F;
              valid_q <= 1'b1;
            end
          end
        end
        HALT: begin
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          run_q   <= '0;
        end
      endcase
    end
  end

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] scnt_q;
  logic [CNT_W-1:0] fcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (stallFD && !halted_q && scnt_q != '1)
        scnt_q <= scnt_q + CNT_W'(1);
      if (flushD && !stallFD && !halted_q && fcnt_q != '1)
        fcnt_q <= fcnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = scnt_q;
  assign flush_cnt = fcnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fd_stall_ctrl.sv
// Scoreboard bench for fd_stall_ctrl: directed vectors push expectations,
// a monitor pops and compares comb outputs before the edge, registers after.
module tb_fd_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stallFD = 1'b0;
  logic        flushD = 1'b0;
  logic        halt_D = 1'b0;
  logic [15:0] instr_F = '0;
  logic [15:0] pc_plus2_F = '0;
  logic        pc_en, bubble_X, valid_D, halted, stall_err;
  logic [15:0] instr_D, pc_plus2_D, stall_cnt, flush_cnt;

  fd_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stallFD(stallFD), .flushD(flushD),
    .halt_D(halt_D), .instr_F(instr_F), .pc_plus2_F(pc_plus2_F),
    .pc_en(pc_en), .bubble_X(bubble_X), .instr_D(instr_D),
    .pc_plus2_D(pc_plus2_D), .valid_D(valid_D), .halted(halted),
    .stall_err(stall_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        pcen;
    logic        bub;
    logic [15:0] instr;
    int          pc;
    logic        valid;
    logic        hlt;
    logic        err;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int vid = 0;
  int m_sc = 0;
  int m_fc = 0;
  logic cur_h = 1'b0;

  task automatic chk(input string nm, input int id,
                     input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec%0d: got %h want %h", nm, id, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic fl, input logic ht,
                      input logic rs, input logic [15:0] ins,
                      input logic [15:0] pc, input logic e_pcen,
                      input logic e_bub, input logic [15:0] e_ins,
                      input int e_pc, input logic e_v,
                      input logic e_h, input logic e_err);
    exp_t e;
    @(negedge clk);
    stallFD = st; flushD = fl; halt_D = ht; rst_n = rs;
    instr_F = ins; pc_plus2_F = pc;
    if (!rs) begin
      m_sc = 0; m_fc = 0;
    end else begin
      if (st && !cur_h) m_sc++;
      if (fl && !st && !cur_h) m_fc++;
    end
    cur_h = e_h;
    e.id = vid; e.pcen = e_pcen; e.bub = e_bub; e.instr = e_ins;
    e.pc = e_pc; e.valid = e_v; e.hlt = e_h; e.err = e_err;
`ifdef STALL_PERF_EN
    e.scnt = 16'(m_sc); e.fcnt = 16'(m_fc);
`else
    e.scnt = '0; e.fcnt = '0;
`endif
    q.push_back(e);
    vid++;
  endtask

  initial begin : monitor
    exp_t r;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        r = q.pop_front();
        chk("pc_en", r.id, 16'(pc_en), 16'(r.pcen));
        chk("bubble_X", r.id, 16'(bubble_X), 16'(r.bub));
        @(posedge clk);
        #1;
        chk("instr_D", r.id, instr_D, r.instr);
        if (r.pc >= 0)
          chk("pc_plus2_D", r.id, pc_plus2_D, 16'(r.pc));
        chk("valid_D", r.id, 16'(valid_D), 16'(r.valid));
        chk("halted", r.id, 16'(halted), 16'(r.hlt));
        chk("stall_err", r.id, 16'(stall_err), 16'(r.err));
        chk("stall_cnt", r.id, stall_cnt, r.scnt);
        chk("flush_cnt", r.id, flush_cnt, r.fcnt);
      end
    end
  end

  initial begin : stim
    // st fl ht rs instr pc | pcen bub instr_D pc valid halt err
    step(0,0,0,0,16'h0000,16'h0000, 1,0,16'h0000, 0,0,0,0);
    step(0,0,0,1,16'h1234,16'h0002, 1,0,16'h1234, 2,1,0,0);
    step(0,0,0,1,16'h1234,16'h0004, 1,0,16'h1234, 4,1,0,0);
    step(0,0,0,1,16'h1234,16'h0006, 1,0,16'h1234, 6,1,0,0);
    // two-cycle stall: legal
    step(1,0,0,1,16'h5555,16'h0008, 0,1,16'h1234, 6,1,0,0);
    step(1,0,0,1,16'h6666,16'h0008, 0,1,16'h1234, 6,1,0,0);
    step(0,0,0,1,16'h2222,16'h0008, 1,0,16'h2222, 8,1,0,0);
    // three-cycle stall: error on third edge, sticky
    step(1,0,0,1,16'h3333,16'h000A, 0,1,16'h2222, 8,1,0,0);
    step(1,0,0,1,16'h3333,16'h000A, 0,1,16'h2222, 8,1,0,0);
    step(1,0,0,1,16'h3333,16'h000A, 0,1,16'h2222, 8,1,0,1);
    step(0,0,0,1,16'h3333,16'h000A, 1,0,16'h3333,10,1,0,1);
    // stall beats flush, then flush alone
    step(1,1,0,1,16'h4444,16'h000C, 0,1,16'h3333,10,1,0,1);
    step(0,1,0,1,16'h4444,16'h000C, 1,0,16'h0000,12,0,0,1);
    // flush beats halt
    step(0,1,1,1,16'h7777,16'h000E, 1,0,16'h0000,14,0,0,1);
    // halt with valid_D=0 ignored
    step(0,0,1,1,16'h8888,16'h0010, 1,0,16'h8888,16,1,0,1);
    // halt taken
    step(0,0,1,1,16'h9999,16'h0012, 1,0,16'h0000,-1,0,1,1);
    step(0,0,0,1,16'hAAAA,16'h0014, 0,1,16'h0000,-1,0,1,1);
    step(1,0,0,1,16'hAAAA,16'h0014, 0,1,16'h0000,-1,0,1,1);
    // reset pulse leaves halt
    step(0,0,0,0,16'hAAAA,16'h0014, 1,0,16'h0000, 0,0,0,0);
    step(0,0,0,1,16'hBBBB,16'h0002, 1,0,16'hBBBB, 2,1,0,0);
    // reset mid-stall discards held instruction
    step(1,0,0,1,16'hCCCC,16'h0004, 0,1,16'hBBBB, 2,1,0,0);
    step(0,0,0,0,16'hCCCC,16'h0004, 1,0,16'h0000, 0,0,0,0);
    step(0,0,0,1,16'hDDDD,16'h0004, 1,0,16'hDDDD, 4,1,0,0);
    step(0,1,0,1,16'hEEEE,16'h0006, 1,0,16'h0000, 6,0,0,0);
    step(0,0,0,1,16'hF00F,16'h0008, 1,0,16'hF00F, 8,1,0,0);
    repeat (4) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
